// File: rtl/viterbi_ber_checker.sv
// BER checker for a Viterbi decoder: searches the decoder latency against the source stream,
// then counts bit errors and mismatches while aligned, dropping lock on dense error windows.
module viterbi_ber_checker #(
  parameter int unsigned MAX_LAT   = 64,
  parameter int unsigned LOCK_LEN  = 32,
  parameter int unsigned WIN       = 64,
  parameter int unsigned LOSS_ERRS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ref_valid_i,
  input  logic                       ref_bit_i,
  input  logic                       dec_valid_i,
  input  logic                       dec_bit_i,
  input  logic                       clear_i,
  output logic                       locked_o,
  output logic [$clog2(MAX_LAT)-1:0] latency_o,
  output logic [31:0]                bit_cnt_o,
  output logic [31:0]                err_cnt_o,
  output logic                       err_pulse_o,
  output logic [7:0]                 lock_loss_cnt_o
);

  localparam int unsigned LatW   = $clog2(MAX_LAT);
  localparam int unsigned MatchW = $clog2(LOCK_LEN + 1);
  localparam int unsigned WinW   = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int unsigned ErrW   = $clog2(LOSS_ERRS + 1);

  typedef enum logic {StSearch, StLocked} state_e;

  state_e              state_q, state_d;
  logic [MAX_LAT-1:0]  hist_q, hist_d;
  logic [LatW-1:0]     dly_q, dly_d;
  logic [LatW-1:0]     lat_q, lat_d;
  logic [MatchW-1:0]   match_q, match_d;
  logic [WinW-1:0]     win_q, win_d;
  logic [ErrW-1:0]     werr_q, werr_d;
  logic [31:0]         bit_q, bit_d;
  logic [31:0]         err_q, err_d;
  logic [7:0]          loss_q, loss_d;
  logic                pulse_q, pulse_d;

  logic                mismatch;
  logic [31:0]         bit_base, err_base;
  logic [7:0]          loss_base;

  // Compare against the history as it stood before this cycle's shift.
  assign mismatch = dec_bit_i ^ hist_q[dly_q];

  always_comb begin
    state_d   = state_q;
    hist_d    = ref_valid_i ? {hist_q[MAX_LAT-2:0], ref_bit_i} : hist_q;
    dly_d     = dly_q;
    lat_d     = lat_q;
    match_d   = match_q;
    win_d     = win_q;
    werr_d    = werr_q;
    pulse_d   = 1'b0;
    bit_base  = clear_i ? '0 : bit_q;
    err_base  = clear_i ? '0 : err_q;
    loss_base = clear_i ? '0 : loss_q;
    bit_d     = bit_base;
    err_d     = err_base;
    loss_d    = loss_base;

    if (dec_valid_i) begin
      unique case (state_q)
        StSearch: begin
          if (mismatch) begin
            match_d = '0;
            dly_d   = dly_q + 1'b1;
          end else if (match_q == MatchW'(LOCK_LEN - 1)) begin
            state_d = StLocked;
            lat_d   = dly_q;
            match_d = '0;
            win_d   = '0;
            werr_d  = '0;
          end else begin
            match_d = match_q + 1'b1;
          end
        end
        StLocked: begin
          if (bit_base != '1) bit_d = bit_base + 1'b1;
          if (mismatch) begin
            pulse_d = 1'b1;
            if (err_base != '1) err_d = err_base + 1'b1;
          end
          if (mismatch && werr_q == ErrW'(LOSS_ERRS - 1)) begin
            state_d = StSearch;
            match_d = '0;
            win_d   = '0;
            werr_d  = '0;
            if (loss_base != 8'hff) loss_d = loss_base + 1'b1;
          end else if (win_q == WinW'(WIN - 1)) begin
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d = win_q + 1'b1;
            if (mismatch) werr_d = werr_q + 1'b1;
          end
        end
        default: state_d = StSearch;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StSearch;
      hist_q  <= '0;
      dly_q   <= '0;
      lat_q   <= '0;
      match_q <= '0;
      win_q   <= '0;
      werr_q  <= '0;
      bit_q   <= '0;
      err_q   <= '0;
      loss_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      dly_q   <= dly_d;
      lat_q   <= lat_d;
      match_q <= match_d;
      win_q   <= win_d;
      werr_q  <= werr_d;
      bit_q   <= bit_d;
      err_q   <= err_d;
      loss_q  <= loss_d;
      pulse_q <= pulse_d;
    end
  end

  assign locked_o        = (state_q == StLocked);
  assign latency_o       = lat_q;
  assign bit_cnt_o       = bit_q;
  assign err_cnt_o       = err_q;
  assign err_pulse_o     = pulse_q;
  assign lock_loss_cnt_o = loss_q;

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Randomized bench for viterbi_ber_checker against a behavioural alignment/BER model.
module tb_viterbi_ber_checker;

  localparam int unsigned MaxLat   = 64;
  localparam int unsigned LockLen  = 32;
  localparam int unsigned Win      = 64;
  localparam int unsigned LossErrs = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ref_valid_i = 1'b0, ref_bit_i = 1'b0;
  logic       dec_valid_i = 1'b0, dec_bit_i = 1'b0;
  logic       clear_i = 1'b0;
  logic       locked_o;
  logic [5:0] latency_o;
  logic [31:0] bit_cnt_o, err_cnt_o;
  logic       err_pulse_o;
  logic [7:0] lock_loss_cnt_o;

  viterbi_ber_checker #(
    .MAX_LAT(MaxLat), .LOCK_LEN(LockLen), .WIN(Win), .LOSS_ERRS(LossErrs)
  ) dut (
    .clk(clk), .rst(rst),
    .ref_valid_i(ref_valid_i), .ref_bit_i(ref_bit_i),
    .dec_valid_i(dec_valid_i), .dec_bit_i(dec_bit_i),
    .clear_i(clear_i),
    .locked_o(locked_o), .latency_o(latency_o),
    .bit_cnt_o(bit_cnt_o), .err_cnt_o(err_cnt_o),
    .err_pulse_o(err_pulse_o), .lock_loss_cnt_o(lock_loss_cnt_o)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: source bits since reset (newest first) plus alignment/statistics state.
  bit          q_ref[$];
  bit          m_locked, m_pulse;
  int          m_d, m_match, m_lat, m_win, m_werr, m_loss;
  int unsigned m_bits, m_errs;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit ref_at(input int k);
    return (k < q_ref.size()) ? q_ref[k] : 1'b0;
  endfunction

  task automatic model_reset();
    q_ref.delete();
    m_locked = 0; m_pulse = 0; m_d = 0; m_match = 0; m_lat = 0;
    m_win = 0; m_werr = 0; m_loss = 0; m_bits = 0; m_errs = 0;
  endtask

  task automatic model_step(input bit rv, input bit rb, input bit dv, input bit db, input bit clr);
    bit mis;
    mis = db ^ ref_at(m_d);
    if (clr) begin m_bits = 0; m_errs = 0; m_loss = 0; end
    m_pulse = 0;
    if (dv) begin
      if (!m_locked) begin
        if (mis) begin
          m_match = 0;
          m_d = (m_d + 1) % MaxLat;
        end else begin
          m_match++;
          if (m_match == LockLen) begin
            m_locked = 1; m_lat = m_d; m_match = 0; m_win = 0; m_werr = 0;
          end
        end
      end else begin
        if (m_bits != 32'hffff_ffff) m_bits++;
        if (mis) begin
          m_pulse = 1;
          if (m_errs != 32'hffff_ffff) m_errs++;
          m_werr++;
        end
        m_win++;
        if (m_werr == LossErrs) begin
          m_locked = 0; m_match = 0; m_win = 0; m_werr = 0;
          if (m_loss < 255) m_loss++;
        end else if (m_win == Win) begin
          m_win = 0; m_werr = 0;
        end
      end
    end
    if (rv) begin
      q_ref.push_front(rb);
      if (q_ref.size() > MaxLat + 8) void'(q_ref.pop_back());
    end
  endtask

  task automatic check_all();
    check_eq("locked", {31'd0, locked_o}, {31'd0, m_locked});
    check_eq("latency", {26'd0, latency_o}, 32'(m_lat));
    check_eq("bit_cnt", bit_cnt_o, m_bits);
    check_eq("err_cnt", err_cnt_o, m_errs);
    check_eq("err_pulse", {31'd0, err_pulse_o}, {31'd0, m_pulse});
    check_eq("lock_loss", {24'd0, lock_loss_cnt_o}, 32'(m_loss));
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_locked"}, {31'd0, locked_o}, 32'd0);
    check_eq({tag, "_latency"}, {26'd0, latency_o}, 32'd0);
    check_eq({tag, "_bits"}, bit_cnt_o, 32'd0);
    check_eq({tag, "_errs"}, err_cnt_o, 32'd0);
    check_eq({tag, "_pulse"}, {31'd0, err_pulse_o}, 32'd0);
    check_eq({tag, "_loss"}, {24'd0, lock_loss_cnt_o}, 32'd0);
  endtask

  task automatic step(input bit rv, input bit rb, input bit dv, input bit db, input bit clr);
    @(negedge clk);
    ref_valid_i = rv; ref_bit_i = rb; dec_valid_i = dv; dec_bit_i = db; clear_i = clr;
    model_step(rv, rb, dv, db, clr);
    @(posedge clk);
    #1;
    check_all();
  endtask

  // One cycle of a decoder whose output lags the source by lat ref events.
  task automatic drive_clean(input int lat, input bit flip);
    bit rb, db;
    rb = 1'($urandom);
    db = ref_at(lat) ^ flip;
    step(1'b1, rb, 1'b1, db, 1'b0);
  endtask

  task automatic run_lock(input int lat, input int max_cmp);
    int n;
    n = 0;
    while (!m_locked && n < max_cmp) begin
      drive_clean(lat, 1'b0);
      n++;
    end
    check_eq("lock_reached", {31'd0, locked_o}, 32'd1);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_zero(tag);
    model_reset();
    ref_valid_i = 0; ref_bit_i = 0; dec_valid_i = 0; dec_bit_i = 0; clear_i = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int pulses, n;
    bit seen;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Clean stream at latency 5.
    run_lock(5, 500);
    check_eq("lat5", {26'd0, latency_o}, 32'd5);
    check_eq("lat5_errs", err_cnt_o, 32'd0);
    repeat (10) drive_clean(5, 1'b0);

    // One flipped bit in eight over 256 compares.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    pulses = 0;
    for (int i = 0; i < 256; i++) begin
      drive_clean(5, (i % 8) == 7);
      if (err_pulse_o) pulses++;
    end
    check_eq("ber_errs", err_cnt_o, 32'd32);
    check_eq("ber_bits", bit_cnt_o, 32'd256);
    check_eq("ber_pulses", 32'(pulses), 32'd32);
    check_eq("ber_locked", {31'd0, locked_o}, 32'd1);

    // Error burst forces loss of lock, then relock at the same delay.
    n = 0;
    while (m_locked && n < 80) begin
      drive_clean(5, 1'b1);
      n++;
    end
    check_eq("loss_unlocked", {31'd0, locked_o}, 32'd0);
    check_eq("loss_cnt", {24'd0, lock_loss_cnt_o}, 32'd1);
    run_lock(5, MaxLat + 32);
    check_eq("relock_lat", {26'd0, latency_o}, 32'd5);

    // Clear coinciding with a locked mismatch.
    step(1'b1, 1'($urandom), 1'b1, ref_at(5) ^ 1'b1, 1'b1);
    check_eq("clr_errs", err_cnt_o, 32'd1);
    check_eq("clr_bits", bit_cnt_o, 32'd1);
    check_eq("clr_locked", {31'd0, locked_o}, 32'd1);

    // Random valids, sparse errors, periodic bursts and random clears.
    for (int i = 0; i < 1500; i++) begin
      bit rv, dv, fl, cl;
      rv = ($urandom_range(3, 0) != 0);
      dv = ($urandom_range(3, 0) != 0);
      fl = ((i % 400) >= 380) || ($urandom_range(31, 0) == 0);
      cl = ($urandom_range(127, 0) == 0);
      step(rv, 1'($urandom), dv, ref_at(5) ^ fl, cl);
    end

    // Asynchronous reset in the middle of lock.
    run_lock(5, 500);
    do_reset("midlock");
    run_lock(5, 500);
    check_eq("post_rst_lat", {26'd0, latency_o}, 32'd5);

    // Largest delay in range: search must step through 63 positions.
    do_reset("pre63");
    run_lock(63, 4000);
    check_eq("lat63", {26'd0, latency_o}, 32'd63);

    // Out-of-range delay never aligns.
    do_reset("pre64");
    seen = 0;
    for (int i = 0; i < 3000; i++) begin
      drive_clean(64, 1'b0);
      if (locked_o) seen = 1;
    end
    check_eq("lat64_never", {31'd0, seen}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/viterbi_ber_checker.md
VITERBI_BER_CHECKER -- requirements
Module: viterbi_ber_checker

Interface
REQ-001 Parameter MAX_LAT, default 64, meaning: number of candidate alignment delays searched (0..MAX_LAT-1), power of 2.
REQ-002 Parameter LOCK_LEN, default 32, meaning: consecutive matches needed to declare lock.
REQ-003 Parameter WIN, default 64, meaning: length, in compared bits, of the loss-of-lock window.
REQ-004 Parameter LOSS_ERRS, default 16, meaning: number of errors within one window that forces loss of lock.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous reset, active-high.
REQ-008 ref_valid_i  input  1  a source bit (the encoder input) is present.
REQ-009 ref_bit_i  input  1  the source bit.
REQ-010 dec_valid_i  input  1  a decoded bit (the decoder output) is present.
REQ-011 dec_bit_i  input  1  the decoded bit.
REQ-012 clear_i  input  1  synchronous clear of the statistics counters.
REQ-013 locked_o  output  1  alignment found.
REQ-014 latency_o  output  log2(MAX_LAT)  locked delay, in ref_valid events.
REQ-015 bit_cnt_o  output  32  number of bits compared while LOCKED.
REQ-016 err_cnt_o  output  32  number of mismatches while LOCKED.
REQ-017 err_pulse_o  output  1  one-cycle pulse, registered, on each LOCKED mismatch.
REQ-018 lock_loss_cnt_o  output  8  number of LOCKED-to-SEARCH transitions, saturating.

Function
REQ-019 The block SHALL keep a MAX_LAT-bit history shift register: on ref_valid_i, hist <= {hist[MAX_LAT-2:0], ref_bit_i}, so hist[0] is the newest captured source bit.
REQ-020 On dec_valid_i, dec_bit_i SHALL be compared against hist[d], where d is the current candidate delay; when ref_valid_i and dec_valid_i occur in the same cycle, the comparison SHALL use the history before the shift.
REQ-021 The FSM SHALL have two states, SEARCH and LOCKED, and SHALL reset to SEARCH with d=0 and match_cnt=0.
REQ-022 In SEARCH, on each match match_cnt SHALL increment.
REQ-023 In SEARCH, on a mismatch match_cnt SHALL reset to 0 and d SHALL advance by 1, wrapping from MAX_LAT-1 to 0.
REQ-024 In SEARCH, when a compare raises match_cnt to LOCK_LEN, the FSM SHALL move to LOCKED on the next edge, and latency_o SHALL be set to d and held.
REQ-025 During SEARCH, bit_cnt_o and err_cnt_o SHALL NOT change.
REQ-026 In LOCKED, each compare SHALL increment bit_cnt_o, and each mismatch SHALL also increment err_cnt_o and assert err_pulse_o on the next cycle.
REQ-027 Both counters SHALL saturate at 2^32-1.
REQ-028 In LOCKED, a window counter SHALL count compares from 0 to WIN-1 alongside a window error count; when the window wraps, both SHALL restart from 0.
REQ-029 When the window error count reaches LOSS_ERRS, the FSM SHALL return to SEARCH next cycle, keeping the same d, with match_cnt=0.
REQ-030 On loss of lock, lock_loss_cnt_o SHALL increment, saturating at 255.
REQ-031 locked_o SHALL equal (state==LOCKED), registered.
REQ-032 latency_o SHALL read 0 until the first lock.
REQ-033 clear_i SHALL zero bit_cnt_o, err_cnt_o and lock_loss_cnt_o without affecting the FSM, d, the window or the history.
REQ-034 When clear_i and a compare occur in the same cycle, the cleared value plus that cycle's increment (0 or 1) SHALL be loaded.
REQ-035 When dec_valid_i is low, no compare SHALL occur and no state, counter or window SHALL change, apart from the history shift on ref_valid_i.

Reset
REQ-036 While rst is high, all outputs SHALL be 0, the FSM SHALL be in SEARCH with d=0, and the history, match_cnt and window counters SHALL be 0; this takes effect asynchronously, including mid-lock.
REQ-037 After rst falls, the first compare SHALL occur on the first dec_valid_i sampled on a rising edge.

Verification
REQ-038 Decoded stream = source delayed by 5 ref events, no errors, both valids high every cycle -> locked_o rises after 5 mismatch-advance compares plus 32 matches; latency_o=5; err_cnt_o=0.
REQ-039 Locked at latency 5, flip 1 decoded bit in every 8 for 256 bits -> err_cnt_o=32, bit_cnt_o=256, 32 err_pulse_o pulses, locked_o stays 1 (8 errors per window < 16).
REQ-040 Locked, then 16 consecutive corrupted decoded bits -> locked_o falls, lock_loss_cnt_o=1, and the block relocks at latency 5 within MAX_LAT+32 compares.
REQ-041 Decoder delay = 63 -> the search wraps correctly and locks with latency_o=63; delay 64 (out of range) -> locked_o never rises.
REQ-042 clear_i pulsed while locked and during a mismatch compare -> err_cnt_o=1 and bit_cnt_o=1 next cycle, locked_o unchanged.
REQ-043 rst asserted mid-LOCKED between clock edges -> all outputs 0 immediately; after release, relock with the same latency_o.
